// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM state and access-size codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    D_WAIT = 2'd1,
    F_WAIT = 2'd2,
    F_DROP = 2'd3
  } arb_state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts consecutive data grants taken while a fetch is waiting, saturating at LIMIT.
// Latency: count visible the cycle after the grant that changes it.
// Backpressure: none; clears whenever the fetch stage stops asking or wins a grant.
module arb_starve_ctr #(
  parameter int unsigned LIMIT = 4,
  parameter int unsigned CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             f_req,
  input  logic             data_gnt,
  input  logic             fetch_gnt,
  output logic [CNT_W-1:0] cnt
);

  // Saturating counter: cleared when fetch is idle or served, bumped per data grant otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (!f_req || fetch_gnt) begin
      cnt <= '0;
    end else if (data_gnt && (cnt != CNT_W'(LIMIT))) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the IF and MEM pipeline stages onto one memory port, one transaction in flight.
// Latency: request combinational in IDLE; done/rvalid combinational from mem_rvalid (0 cycles).
// Backpressure: request held until mem_gnt; stages stalled until their completion pulse.
module mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              f_flush,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_fetch,
  output logic              stall_mem
);

  import mem_arb_pkg::*;

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic             starved;
  logic             idle;
  logic             sel_fetch;
  logic             sel_data;
  logic             data_gnt;
  logic             fetch_gnt;

  // Data normally wins; a fetch that has watched STARVE_LIMIT data grants goes first.
  // A flush in the same cycle withdraws the fetch, since its address is already stale.
  assign starved   = f_req & (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign idle      = (state == IDLE) & ~reset;
  assign sel_fetch = idle & f_req & ~f_flush & (starved | ~d_req);
  assign sel_data  = idle & d_req & ~sel_fetch;
  assign mem_req   = sel_fetch | sel_data;
  assign data_gnt  = sel_data & mem_gnt;
  assign fetch_gnt = sel_fetch & mem_gnt;

  // Request fields follow the selected requester; zero when nothing is offered.
  always_comb begin
    mem_we    = 1'b0;
    mem_size  = 2'b00;
    mem_addr  = '0;
    mem_wdata = '0;
    if (sel_data) begin
      mem_we    = d_we;
      mem_size  = d_size;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (sel_fetch) begin
      mem_size  = SIZE_WORD;
      mem_addr  = f_addr;
    end
  end

  // Completion pulses come straight off mem_rvalid; a flush in F_WAIT kills the fetch pulse.
  assign d_done      = ~reset & (state == D_WAIT) & mem_rvalid;
  assign f_rvalid    = ~reset & (state == F_WAIT) & mem_rvalid & ~f_flush;
  assign d_rdata     = d_done   ? mem_rdata : '0;
  assign f_rdata     = f_rvalid ? mem_rdata : '0;
  assign stall_mem   = ~reset & d_req & ~d_done;
  assign stall_fetch = ~reset & f_req & ~f_rvalid;

  // Next-state: one transaction in flight; flushed fetches drain through F_DROP.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (data_gnt) begin
          state_nxt = D_WAIT;
        end else if (fetch_gnt) begin
          state_nxt = F_WAIT;
        end
      end
      D_WAIT: begin
        if (mem_rvalid) begin
          state_nxt = IDLE;
        end
      end
      F_WAIT: begin
        if (mem_rvalid) begin
          state_nxt = IDLE;
        end else if (f_flush) begin
          state_nxt = F_DROP;
        end
      end
      F_DROP: begin
        if (mem_rvalid) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset abandons any transaction so its late response lands in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT),
    .CNT_W (CNT_W)
  ) u_starve_ctr (
    .clk       (clk),
    .reset     (reset),
    .f_req     (f_req),
    .data_gnt  (data_gnt),
    .fetch_gnt (fetch_gnt),
    .cnt       (starve_cnt)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: pipeline stages, memory and a transaction-level model.
// Latency: checks combinational outputs each cycle just after inputs settle.
// Backpressure: random mem_gnt withholding and variable response latency.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;
  localparam int NCYC = 4000;

  logic          clk = 1'b0;
  logic          reset;
  logic          f_req, f_flush, f_rvalid;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_rdata;
  logic          d_req, d_we, d_done;
  logic [1:0]    d_size;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [1:0]    mem_size;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          stall_fetch, stall_mem;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_flush(f_flush),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall_fetch(stall_fetch), .stall_mem(stall_mem)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic chk_all_zero();
    chk("rst_mem_req",     64'(mem_req),     64'(0));
    chk("rst_mem_we",      64'(mem_we),      64'(0));
    chk("rst_mem_size",    64'(mem_size),    64'(0));
    chk("rst_mem_addr",    64'(mem_addr),    64'(0));
    chk("rst_mem_wdata",   64'(mem_wdata),   64'(0));
    chk("rst_f_rvalid",    64'(f_rvalid),    64'(0));
    chk("rst_f_rdata",     64'(f_rdata),     64'(0));
    chk("rst_d_done",      64'(d_done),      64'(0));
    chk("rst_d_rdata",     64'(d_rdata),     64'(0));
    chk("rst_stall_fetch", 64'(stall_fetch), 64'(0));
    chk("rst_stall_mem",   64'(stall_mem),   64'(0));
  endtask

  // Stimulus phases: data request rate, fetch request rate, grant rate, max response latency.
  int unsigned d_pct   [4] = '{95, 50, 30, 70};
  int unsigned f_pct   [4] = '{90, 60, 40, 80};
  int unsigned gnt_pct [4] = '{90, 60, 40, 100};
  int unsigned lat_max [4] = '{1, 3, 4, 2};

  // Transaction-level model: what is in flight, for whom, and whether it was abandoned.
  bit          busy, owner_fetch, abandoned;
  int          starve;
  bit          f_active, d_active;
  logic [AW-1:0] f_a, d_a;
  logic [DW-1:0] d_wd;
  logic        d_w;
  logic [1:0]  d_sz;
  bit          mem_pend;
  int          mem_timer;
  int          rst_left;
  int cov_starve_win, cov_flush_wait, cov_flush_rv, cov_drop, cov_rst_busy, cov_spur, cov_stall_gnt;

  initial begin
    reset = 1'b1; f_req = 0; f_addr = 0; f_flush = 0;
    d_req = 0; d_we = 0; d_size = 0; d_addr = 0; d_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    busy = 0; owner_fetch = 0; abandoned = 0; starve = 0;
    f_active = 0; d_active = 0; f_a = 0; d_a = 0; d_wd = 0; d_w = 0; d_sz = 0;
    mem_pend = 0; mem_timer = 0; rst_left = 0;
    cov_starve_win = 0; cov_flush_wait = 0; cov_flush_rv = 0; cov_drop = 0;
    cov_rst_busy = 0; cov_spur = 0; cov_stall_gnt = 0;

    repeat (3) begin
      @(negedge clk);
      #1;
      chk_all_zero();
    end
    chk("rst_starve_cnt", 64'(dut.starve_cnt), 64'(0));

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      int  ph;
      bit  exp_fsel, exp_dsel, exp_req, exp_done, exp_frv, grant, was_busy;
      ph = cyc / (NCYC / 4);
      @(negedge clk);

      if (rst_left == 0 && cyc > 20 && $urandom_range(0, 149) == 0) rst_left = $urandom_range(1, 2);
      reset = (rst_left > 0);

      if (!f_active && $urandom_range(0, 99) < f_pct[ph]) begin
        f_active = 1; f_a = $urandom;
      end
      if (!d_active && $urandom_range(0, 99) < d_pct[ph]) begin
        d_active = 1; d_a = $urandom; d_wd = $urandom;
        d_w = 1'($urandom_range(0, 1)); d_sz = 2'($urandom_range(0, 2));
      end
      f_req = f_active; f_addr = f_a;
      d_req = d_active; d_addr = d_a; d_wdata = d_wd; d_we = d_w; d_size = d_sz;
      f_flush    = ($urandom_range(0, 99) < (f_active ? 6 : 2));
      mem_gnt    = !mem_pend && ($urandom_range(0, 99) < gnt_pct[ph]);
      mem_rvalid = mem_pend ? (mem_timer == 1) : ($urandom_range(0, 19) == 0);
      mem_rdata  = $urandom;
      #1;

      chk("starve_cnt", 64'(dut.starve_cnt), 64'(starve));

      exp_fsel = !busy && f_req && !f_flush && (!d_req || starve >= LIM);
      exp_dsel = !busy && d_req && !exp_fsel;
      exp_req  = exp_fsel || exp_dsel;
      exp_done = busy && !owner_fetch && mem_rvalid;
      exp_frv  = busy && owner_fetch && !abandoned && mem_rvalid && !f_flush;

      if (reset) begin
        chk_all_zero();
      end else begin
        chk("mem_req", 64'(mem_req), 64'(exp_req));
        if (exp_req) begin
          chk("mem_addr", 64'(mem_addr), exp_dsel ? 64'(d_a) : 64'(f_a));
          chk("mem_we",   64'(mem_we),   exp_dsel ? 64'(d_w) : 64'(0));
          chk("mem_size", 64'(mem_size), exp_dsel ? 64'(d_sz) : 64'(SIZE_WORD));
          if (exp_dsel) chk("mem_wdata", 64'(mem_wdata), 64'(d_wd));
        end
        chk("d_done",   64'(d_done),   64'(exp_done));
        chk("f_rvalid", 64'(f_rvalid), 64'(exp_frv));
        if (exp_done) chk("d_rdata", 64'(d_rdata), 64'(mem_rdata));
        if (exp_frv)  chk("f_rdata", 64'(f_rdata), 64'(mem_rdata));
        chk("stall_mem",   64'(stall_mem),   64'(d_req && !exp_done));
        chk("stall_fetch", 64'(stall_fetch), 64'(f_req && !exp_frv));
      end

      // Advance the model across the clock edge.
      grant    = !reset && exp_req && mem_gnt;
      was_busy = busy;
      if (reset) begin
        if (busy) cov_rst_busy++;
        busy = 0; starve = 0; f_active = 0; d_active = 0;
        rst_left--;
      end else begin
        if (!was_busy && mem_rvalid) cov_spur++;
        if (exp_req && !mem_gnt && cyc > 0) cov_stall_gnt++;
        if (busy && mem_rvalid) begin
          if (owner_fetch && abandoned) cov_drop++;
          if (owner_fetch && !abandoned && f_flush) cov_flush_rv++;
          busy = 0;
        end else if (busy && owner_fetch && f_flush && !abandoned) begin
          abandoned = 1; cov_flush_wait++;
        end
        if (grant) begin
          if (exp_fsel && d_req) cov_starve_win++;
          busy = 1; owner_fetch = exp_fsel; abandoned = 0;
        end
        if (!f_req || (grant && exp_fsel)) starve = 0;
        else if (grant && exp_dsel) starve = (starve + 1 > LIM) ? LIM : starve + 1;
        if (exp_done) d_active = 0;
        if (exp_frv)  f_active = 0;
        if (f_flush && f_active) f_a = $urandom;
      end
      if (mem_pend) begin
        if (mem_timer == 1) mem_pend = 0;
        else mem_timer--;
      end
      if (grant) begin
        mem_pend = 1; mem_timer = $urandom_range(1, lat_max[ph]);
      end
    end

    chk("cov_starved_fetch_win", 64'(cov_starve_win > 0), 64'(1));
    chk("cov_flush_in_f_wait",   64'(cov_flush_wait > 0), 64'(1));
    chk("cov_flush_with_rvalid", 64'(cov_flush_rv > 0),   64'(1));
    chk("cov_dropped_response",  64'(cov_drop > 0),       64'(1));
    chk("cov_reset_while_busy",  64'(cov_rst_busy > 0),   64'(1));
    chk("cov_rvalid_in_idle",    64'(cov_spur > 0),       64'(1));
    chk("cov_gnt_withheld",      64'(cov_stall_gnt > 0),  64'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, memory address width.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter STARVE_LIMIT, default 4, consecutive data grants allowed while a fetch waits.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 f_req  input  1  IF stage requests an instruction read; held until f_rvalid.
REQ-007 f_addr  input  ADDR_W  fetch address; stable while f_req is high.
REQ-008 f_rvalid  output  1  one-cycle pulse: f_rdata valid, fetch complete.
REQ-009 f_rdata  output  DATA_W  fetched instruction word.
REQ-010 f_flush  input  1  taken branch; the current or outstanding fetch is abandoned.
REQ-011 d_req  input  1  MEM stage load/store request; held until d_done.
REQ-012 d_we  input  1  1 = store, 0 = load.
REQ-013 d_size  input  2  access size (00 byte, 01 half, 10 word), passed through.
REQ-014 d_addr / d_wdata  input  ADDR_W / DATA_W  data address and store data.
REQ-015 d_done  output  1  one-cycle pulse: data access complete; d_rdata valid for loads.
REQ-016 d_rdata  output  DATA_W  load data.
REQ-017 mem_req / mem_we / mem_size / mem_addr / mem_wdata  output  1/1/2/ADDR_W/DATA_W  shared memory port request.
REQ-018 mem_gnt  input  1  memory accepts the request this cycle.
REQ-019 mem_rvalid / mem_rdata  input  1 / DATA_W  response (read data or write ack), at least 1 cycle after gnt.
REQ-020 stall_fetch / stall_mem  output  1  hold IF / MEM stage of the pipeline.

Function
REQ-021 The FSM SHALL have states IDLE, D_WAIT, F_WAIT, F_DROP, with at most one outstanding memory transaction.
REQ-022 In IDLE, mem_req SHALL be driven combinationally for the selected requester; otherwise mem_req SHALL be 0.
REQ-023 Selection SHALL favour data over fetch, except when starve_cnt == STARVE_LIMIT and f_req is high, in which case fetch wins.
REQ-024 In IDLE, f_flush high SHALL suppress fetch selection that cycle.
REQ-025 IDLE -> D_WAIT SHALL occur on mem_gnt with data selected; IDLE -> F_WAIT SHALL occur on mem_gnt with fetch selected.
REQ-026 Request fields SHALL stay stable while mem_req is high and mem_gnt is low.
REQ-027 In D_WAIT, mem_rvalid SHALL pulse d_done, drive d_rdata = mem_rdata and return to IDLE.
REQ-028 In F_WAIT, mem_rvalid without f_flush SHALL pulse f_rvalid, drive f_rdata and return to IDLE.
REQ-029 In F_WAIT, f_flush SHALL move to F_DROP, or straight to IDLE with no f_rvalid if mem_rvalid is in the same cycle.
REQ-030 In F_DROP, mem_rvalid SHALL be discarded (no f_rvalid) with a return to IDLE; f_flush SHALL be ignored.
REQ-031 mem_rvalid in IDLE SHALL be ignored.
REQ-032 starve_cnt (width clog2(STARVE_LIMIT+1)) SHALL increment on each data grant while f_req is high, saturate at STARVE_LIMIT, and clear on any fetch grant or when f_req is low.
REQ-033 stall_mem SHALL equal d_req & ~d_done; stall_fetch SHALL equal f_req & ~f_rvalid.
REQ-034 Output pulses SHALL be combinational from mem_rvalid in the same cycle: latency from mem_rvalid to done/rvalid is 0 cycles.

Reset
REQ-035 reset SHALL force IDLE and starve_cnt = 0; any response arriving afterwards SHALL be ignored per REQ-031.
REQ-036 While reset is high, all outputs SHALL be 0, including mem_req, f_rvalid, d_done and both stalls.

Structure
REQ-037 Package mem_arb_pkg SHALL hold the state enum (arb_state_t) and the size encodings.
REQ-038 The starvation counter SHALL be one sub-module, arb_starve_ctr, and the rest flat.

Verification
REQ-039 f_req and d_req rise together, mem_gnt immediate, rvalid after 2 cycles -> data served first, d_done at cycle 3, then fetch granted.
REQ-040 d_req held high for 5 back-to-back accesses with f_req high -> 5th arbitration grants fetch and starve_cnt returns to 0.
REQ-041 Fetch granted, f_flush one cycle later, mem_rvalid 3 cycles after gnt -> no f_rvalid, FSM back in IDLE after the drop.
REQ-042 Store d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, mem_gnt held low 3 cycles -> mem_req and fields stable for 4 cycles, stall_mem high until d_done.
REQ-043 reset asserted in D_WAIT, mem_rvalid the cycle after release -> no d_done, state IDLE, all outputs 0 during reset.
REQ-044 f_flush and mem_rvalid in the same F_WAIT cycle -> no f_rvalid, IDLE next cycle.
